// File: rtl/packet_pkg.sv
// Shared types and constants for the Ethernet-style packet receive parser.
package packet_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int ETH_HDR_BYTES  = 14;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_NO_SOP   = 3'd1,
    ERR_NO_EOP   = 3'd2,
    ERR_BE       = 3'd3,
    ERR_RUNT     = 3'd4,
    ERR_OVERSIZE = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR1,
    ST_BODY,
    ST_DROP
  } state_e;

endpackage

// File: rtl/packet_be_decode.sv
// Byte-enable decode: number of enabled bytes and legality of the mask for
// the current word (full mask mid-packet, MSB-aligned contiguous on eop).
module packet_be_decode
  import packet_pkg::*;
(
  input  logic [7:0] be,
  input  logic       eop,
  output logic [3:0] count,
  output logic       legal
);

  logic [7:0] inv;

  always_comb begin
    count = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      count = count + {3'd0, be[i]};
    end
    // An MSB-aligned run of ones inverts to a low run of ones (2^n - 1).
    inv = ~be;
    if (eop) begin
      legal = (be != 8'h00) && ((inv & (inv + 8'd1)) == 8'h00);
    end else begin
      legal = (be == 8'hFF);
    end
  end

endmodule

// File: rtl/packet_rx_parser.sv
// Receive-side packet parser: extracts MAC/ethertype header fields, counts
// packet bytes and classifies framing, byte-enable and length errors.
module packet_rx_parser
  import packet_pkg::*;
#(
  parameter int MAX_BYTES = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [63:0] data,
  input  logic [7:0]  byte_enable,
  input  logic        sop,
  input  logic        eop,
  output logic [47:0] dst_mac,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        hdr_valid,
  output logic        pkt_done,
  output logic [15:0] pkt_len,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [31:0] pkt_count,
  output logic [15:0] err_count
);

  localparam logic [16:0] MaxLen       = 17'(MAX_BYTES);
  localparam logic [3:0]  HdrTailBytes = 4'(ETH_HDR_BYTES - BYTES_PER_WORD);

  state_e      state_q, state_d;
  logic [47:0] dst_q, dst_d, src_q, src_d;
  logic [15:0] type_q, type_d, acc_q, acc_d;
  logic        hdr_valid_q, hdr_valid_d, pkt_done_q, pkt_done_d;
  logic [15:0] pkt_len_q, pkt_len_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [15:0] err_count_q, err_count_d;

  logic [3:0]  be_cnt;
  logic        be_legal;
  logic        closed;
  logic [15:0] len_new;

  packet_be_decode u_be_decode (
    .be    (byte_enable),
    .eop   (eop),
    .count (be_cnt),
    .legal (be_legal)
  );

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    src_d       = src_q;
    type_d      = type_q;
    acc_d       = acc_q;
    hdr_valid_d = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_len_d   = pkt_len_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    closed      = 1'b0;
    len_new     = sat_add(acc_q, be_cnt);

    if (valid) begin
      if (sop) begin
        // A sop while a packet is open closes it first; that report owns the outputs.
        if (state_q != ST_IDLE) begin
          closed     = 1'b1;
          err_d      = 1'b1;
          err_code_d = ERR_NO_EOP;
          if (state_q != ST_DROP) begin
            pkt_done_d = 1'b1;
            pkt_len_d  = acc_q;
          end
        end
        acc_d = {12'd0, be_cnt};
        if (!be_legal) begin
          if (!closed) begin
            err_d      = 1'b1;
            err_code_d = ERR_BE;
          end
          state_d = eop ? ST_IDLE : ST_DROP;
        end else begin
          dst_d        = data[63:16];
          src_d[47:32] = data[15:0];
          if (eop) begin
            if (!closed) begin
              pkt_done_d = 1'b1;
              pkt_len_d  = {12'd0, be_cnt};
              err_d      = 1'b1;
              err_code_d = ERR_RUNT;
            end
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HDR1;
          end
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            err_d      = 1'b1;
            err_code_d = ERR_NO_SOP;
          end
          ST_HDR1, ST_BODY: begin
            if (!be_legal) begin
              err_d      = 1'b1;
              err_code_d = ERR_BE;
              state_d    = eop ? ST_IDLE : ST_DROP;
            end else begin
              acc_d = len_new;
              if (state_q == ST_HDR1 && (!eop || be_cnt >= HdrTailBytes)) begin
                src_d[31:0] = data[63:32];
                type_d      = data[31:16];
                hdr_valid_d = 1'b1;
              end
              if (eop) begin
                pkt_done_d = 1'b1;
                pkt_len_d  = len_new;
                state_d    = ST_IDLE;
                if (state_q == ST_HDR1 && be_cnt < HdrTailBytes) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_RUNT;
                end else if ({1'b0, len_new} > MaxLen) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_OVERSIZE;
                end
              end else begin
                state_d = ST_BODY;
              end
            end
          end
          ST_DROP: begin
            if (eop) state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (pkt_done_d && !err_d) pkt_count_d = pkt_count_q + 32'd1;
    if (err_d && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
      acc_q       <= '0;
      hdr_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_len_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      type_q      <= type_d;
      acc_q       <= acc_d;
      hdr_valid_q <= hdr_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_len_q   <= pkt_len_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign dst_mac   = dst_q;
  assign src_mac   = src_q;
  assign ethertype = type_q;
  assign hdr_valid = hdr_valid_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_len   = pkt_len_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_packet_rx_parser.sv
// Bench for packet_rx_parser: packets described by length and header bytes,
// expected output events derived per packet and compared against observed events.
module tb_packet_rx_parser;

  localparam int MAX = 1518;

  logic        clk = 1'b0;
  logic        rst, valid, sop, eop;
  logic [63:0] data;
  logic [7:0]  byte_enable;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] ethertype, pkt_len, err_count;
  logic        hdr_valid, pkt_done, err;
  logic [2:0]  err_code;
  logic [31:0] pkt_count;

  packet_rx_parser #(.MAX_BYTES(MAX)) dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .byte_enable(byte_enable),
    .sop(sop), .eop(eop), .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype),
    .hdr_valid(hdr_valid), .pkt_done(pkt_done), .pkt_len(pkt_len), .err(err),
    .err_code(err_code), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] stamp;
    logic        hv, pd, er;
    logic [15:0] len;
    logic [2:0]  code;
    logic [47:0] dst, src;
    logic [15:0] typ;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          cyc = 0;
  int          cmp = 0;
  int          errs = 0;
  int unsigned m_pkt = 0;
  int          m_err = 0;
  bit          open_flag = 0;
  logic [15:0] open_len = '0;
  bit          gaps = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    ev_t e;
    if (!rst && (hdr_valid || pkt_done || err)) begin
      e = '0;
      e.stamp = cyc;
      e.hv = hdr_valid;
      e.pd = pkt_done;
      e.er = err;
      if (hdr_valid) begin
        e.dst = dst_mac;
        e.src = src_mac;
        e.typ = ethertype;
      end
      if (pkt_done) e.len = pkt_len;
      if (err) e.code = err_code;
      obs_q.push_back(e);
    end
  end

  task automatic drive_word(input logic [63:0] d, input logic [7:0] be, input logic s,
                            input logic e, output int stamp);
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge clk);
      valid = 1'b0;
      data = {$urandom, $urandom};
      byte_enable = 8'($urandom);
      sop = 1'($urandom);
      eop = 1'($urandom);
    end
    @(negedge clk);
    valid = 1'b1;
    data = d;
    byte_enable = be;
    sop = s;
    eop = e;
    stamp = cyc + 1;
  endtask

  task automatic settle();
    @(negedge clk);
    valid = 1'b0;
    sop = 1'b0;
    eop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // One packet of L bytes; trunc omits eop, bad_idx>=0 puts bad_be on that word.
  task automatic send_pkt(input int L, input bit trunc, input int bad_idx,
                          input logic [7:0] bad_be, input logic [111:0] hdr);
    int nw, st, k, r;
    logic [63:0] d;
    logic [7:0] be;
    ev_t e;
    bit any;
    nw = trunc ? L / 8 : (L + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 8; b++) begin
        k = 8 * w + b;
        d[63 - 8 * b -: 8] = (k < 14) ? hdr[111 - 8 * k -: 8] : 8'($urandom);
      end
      be = 8'hFF;
      if (!trunc && w == nw - 1) begin
        r = L - 8 * w;
        be = 8'hFF << (8 - r);
      end
      if (w == bad_idx) be = bad_be;
      drive_word(d, be, w == 0, !trunc && w == nw - 1, st);
      e = '0;
      any = 0;
      if (w == 0 && open_flag) begin
        any = 1; e.er = 1; e.code = 3'd2; e.pd = 1; e.len = open_len; m_err++;
      end
      if (w == 1 && ((bad_idx < 0 && (trunc || L >= 14)) || bad_idx >= 2)) begin
        any = 1; e.hv = 1; e.dst = hdr[111:64]; e.src = hdr[63:16]; e.typ = hdr[15:0];
      end
      if (w == bad_idx) begin
        any = 1; e.er = 1; e.code = 3'd3; m_err++;
      end
      if (bad_idx < 0 && !trunc && w == nw - 1) begin
        any = 1; e.pd = 1;
        e.len = (L > 65535) ? 16'hFFFF : 16'(L);
        if (L < 14) begin
          e.er = 1; e.code = 3'd4; m_err++;
        end else if (L > MAX) begin
          e.er = 1; e.code = 3'd5; m_err++;
        end else begin
          m_pkt++;
        end
      end
      if (any) begin
        e.stamp = 32'(st);
        exp_q.push_back(e);
      end
    end
    open_flag = trunc && bad_idx < 0;
    open_len = 16'(L);
  endtask

  task automatic send_nosop();
    int st;
    ev_t e;
    drive_word({$urandom, $urandom}, 8'hFF, 1'b0, 1'($urandom), st);
    e = '0; e.er = 1; e.code = 3'd1; e.stamp = 32'(st);
    exp_q.push_back(e);
    m_err++;
  endtask

  function automatic logic [111:0] rnd_hdr();
    return {$urandom, $urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; data = '0; byte_enable = '0;
    repeat (3) @(negedge clk);
    cmp++;
    if ({dst_mac, src_mac, ethertype, pkt_len, err_code} !== '0) begin
      errs++; $display("FAIL reset_fields: got %h want 0", {dst_mac, src_mac, ethertype, pkt_len, err_code});
    end
    cmp++;
    if ({hdr_valid, pkt_done, err} !== 3'b000) begin
      errs++; $display("FAIL reset_pulses: got %b want 000", {hdr_valid, pkt_done, err});
    end
    cmp++;
    if ({pkt_count, err_count} !== '0) begin
      errs++; $display("FAIL reset_counters: got %h want 0", {pkt_count, err_count});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_pkt(60, 0, -1, 8'h00, {48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800});
    send_pkt(14, 0, -1, 8'h00, rnd_hdr());
    send_pkt(MAX, 0, -1, 8'h00, rnd_hdr());
    settle();
    cmp++;
    if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL basic_nev: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      cmp++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL basic_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    cmp++; if (pkt_count !== m_pkt) begin errs++; $display("FAIL basic_pkt_count: got %0d want %0d", pkt_count, m_pkt); end
    cmp++; if (err_count !== 16'(m_err)) begin errs++; $display("FAIL basic_err_count: got %0d want %0d", err_count, m_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_runt();
    send_pkt(10, 0, -1, 8'h00, rnd_hdr());
    send_pkt(5, 0, -1, 8'h00, rnd_hdr());
    send_pkt(8, 0, -1, 8'h00, rnd_hdr());
    send_pkt(13, 0, -1, 8'h00, rnd_hdr());
    settle();
    cmp++;
    if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL runt_nev: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      cmp++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL runt_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    cmp++; if (pkt_count !== m_pkt) begin errs++; $display("FAIL runt_pkt_count: got %0d want %0d", pkt_count, m_pkt); end
    cmp++; if (err_count !== 16'(m_err)) begin errs++; $display("FAIL runt_err_count: got %0d want %0d", err_count, m_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_no_eop();
    send_pkt(24, 1, -1, 8'h00, rnd_hdr());
    send_pkt(60, 0, -1, 8'h00, rnd_hdr());
    send_pkt(8, 1, -1, 8'h00, rnd_hdr());
    send_pkt(30, 0, -1, 8'h00, rnd_hdr());
    send_nosop();
    settle();
    cmp++;
    if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL noeop_nev: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      cmp++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL noeop_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    cmp++; if (pkt_count !== m_pkt) begin errs++; $display("FAIL noeop_pkt_count: got %0d want %0d", pkt_count, m_pkt); end
    cmp++; if (err_count !== 16'(m_err)) begin errs++; $display("FAIL noeop_err_count: got %0d want %0d", err_count, m_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_be();
    send_pkt(40, 0, 4, 8'hA0, rnd_hdr());
    send_pkt(64, 0, -1, 8'h00, rnd_hdr());
    send_pkt(40, 0, 2, 8'hF0, rnd_hdr());
    send_pkt(40, 0, 0, 8'hFE, rnd_hdr());
    send_pkt(20, 0, 2, 8'h00, rnd_hdr());
    send_pkt(33, 0, -1, 8'h00, rnd_hdr());
    settle();
    cmp++;
    if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL badbe_nev: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      cmp++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL badbe_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    cmp++; if (pkt_count !== m_pkt) begin errs++; $display("FAIL badbe_pkt_count: got %0d want %0d", pkt_count, m_pkt); end
    cmp++; if (err_count !== 16'(m_err)) begin errs++; $display("FAIL badbe_err_count: got %0d want %0d", err_count, m_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_oversize();
    send_pkt(1600, 0, -1, 8'h00, rnd_hdr());
    send_pkt(MAX + 1, 0, -1, 8'h00, rnd_hdr());
    gaps = 0;
    send_pkt(70000, 0, -1, 8'h00, rnd_hdr());
    gaps = 1;
    settle();
    cmp++;
    if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL oversize_nev: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      cmp++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL oversize_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    cmp++; if (pkt_count !== m_pkt) begin errs++; $display("FAIL oversize_pkt_count: got %0d want %0d", pkt_count, m_pkt); end
    cmp++; if (err_count !== 16'(m_err)) begin errs++; $display("FAIL oversize_err_count: got %0d want %0d", err_count, m_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] eop_bad [4] = '{8'h00, 8'hA0, 8'h7F, 8'hE1};
    logic [7:0] mid_bad [4] = '{8'hF0, 8'h7F, 8'h00, 8'hFE};
    int kind, L, nw, idx;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: send_pkt($urandom_range(1, 13), 0, -1, 8'h00, rnd_hdr());
        1, 2: send_pkt($urandom_range(14, 200), 0, -1, 8'h00, rnd_hdr());
        3: begin
          send_pkt(8 * $urandom_range(1, 10), 1, -1, 8'h00, rnd_hdr());
          send_pkt($urandom_range(14, 100), 0, -1, 8'h00, rnd_hdr());
        end
        4: begin
          L = $urandom_range(16, 100);
          nw = (L + 7) / 8;
          idx = $urandom_range(0, nw - 1);
          send_pkt(L, 0, idx, (idx == nw - 1) ? eop_bad[$urandom_range(0, 3)]
                                              : mid_bad[$urandom_range(0, 3)], rnd_hdr());
        end
        5: send_pkt($urandom_range(MAX + 1, 1700), 0, -1, 8'h00, rnd_hdr());
        default: send_nosop();
      endcase
    end
    settle();
    cmp++;
    if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL random_nev: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      cmp++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL random_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    cmp++; if (pkt_count !== m_pkt) begin errs++; $display("FAIL random_pkt_count: got %0d want %0d", pkt_count, m_pkt); end
    cmp++; if (err_count !== 16'(m_err)) begin errs++; $display("FAIL random_err_count: got %0d want %0d", err_count, m_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    send_pkt(24, 1, -1, 8'h00, rnd_hdr());
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp++;
    if ({dst_mac, src_mac, ethertype, pkt_len, err_code, hdr_valid, pkt_done, err} !== '0) begin
      errs++; $display("FAIL midrst_outputs: got %h want 0",
                       {dst_mac, src_mac, ethertype, pkt_len, err_code, hdr_valid, pkt_done, err});
    end
    cmp++;
    if ({pkt_count, err_count} !== '0) begin
      errs++; $display("FAIL midrst_counters: got %h want 0", {pkt_count, err_count});
    end
    rst = 1'b0;
    m_pkt = 0; m_err = 0; open_flag = 0;
    send_nosop();
    send_pkt(50, 0, -1, 8'h00, rnd_hdr());
    settle();
    cmp++;
    if (obs_q.size() != exp_q.size()) begin errs++; $display("FAIL midrst_nev: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      cmp++; if (obs_q[i] !== exp_q[i]) begin errs++; $display("FAIL midrst_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    cmp++; if (pkt_count !== m_pkt) begin errs++; $display("FAIL midrst_pkt_count: got %0d want %0d", pkt_count, m_pkt); end
    cmp++; if (err_count !== 16'(m_err)) begin errs++; $display("FAIL midrst_err_count: got %0d want %0d", err_count, m_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_runt();
    test_no_eop();
    test_bad_be();
    test_oversize();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
